// File: rtl/serial_cra_addsub_pkg.sv
// Shared definitions for the bit-serial carry-ripple adder/subtractor.
package serial_cra_addsub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_fa_cell.sv
// Combinational 1-bit full adder used as the single serial datapath cell.
module serial_fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_cra_addsub.sv
// Bit-serial add/subtract: one full-adder cell, LSB first, carry flop closes the ripple loop.
module serial_cra_addsub #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    import serial_cra_addsub_pkg::*;

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_MSB_IN = CNT_W'(WIDTH - 2);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
    logic [WIDTH-1:0] r_sum;
    logic [CNT_W-1:0] r_cnt;
    logic             r_carry;
    logic             r_cin_msb;
    logic             r_cout;
    logic             r_ovf;
    logic             w_accept;
    logic             w_s;
    logic             w_c;

    serial_fa_cell u_fa (
        .a    (r_opa[0]),
        .b    (r_opb[0]),
        .cin  (r_carry),
        .s    (w_s),
        .cout (w_c)
    );

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (r_cnt == CNT_LAST) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_accept = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_opa     <= '0;
            r_opb     <= '0;
            r_sum     <= '0;
            r_cnt     <= '0;
            r_carry   <= 1'b0;
            r_cin_msb <= 1'b0;
            r_cout    <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                // Subtract = A + ~B + 1: invert B here and preload the carry.
                r_opa   <= a;
                r_opb   <= (sub == OP_ADD) ? b : ~b;
                r_carry <= (sub == OP_SUB);
                r_cnt   <= '0;
            end else if (r_state == ST_RUN) begin
                r_opa   <= {1'b0, r_opa[WIDTH-1:1]};
                r_opb   <= {1'b0, r_opb[WIDTH-1:1]};
                r_sum   <= {w_s, r_sum[WIDTH-1:1]};
                r_carry <= w_c;
                if (r_cnt == CNT_MSB_IN) r_cin_msb <= w_c;
                if (r_cnt == CNT_LAST) begin
                    r_cout <= w_c;
                    r_ovf  <= r_cin_msb ^ w_c;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign sum      = r_sum;
    assign cout     = r_cout;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_serial_cra_addsub.sv
// Randomized self-checking bench for serial_cra_addsub (WIDTH=8) against an arithmetic reference.
module tb_serial_cra_addsub;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         overflow;

    int n_checks;
    int n_pass;

    serial_cra_addsub #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    // Reference: plain integer arithmetic, unsigned for sum/carry, signed range for overflow.
    task automatic model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                         output logic [W-1:0] r, output logic c, output logic v);
        int ux, uy, full, sx, sy, sr;
        ux = int'(x);
        uy = int'(y);
        sx = int'($signed(x));
        sy = int'($signed(y));
        if (s) begin
            full = ux - uy;
            c    = (ux >= uy);
            sr   = sx - sy;
        end else begin
            full = ux + uy;
            c    = (full > 255);
            sr   = sx + sy;
        end
        r = full[W-1:0];
        v = (sr > 127) || (sr < -128);
    endtask

    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic ts,
                         input int hold, input bit churn);
        logic [W-1:0] es;
        logic         ec;
        logic         ev;
        int           lat;
        bit           seen;
        model(ta, tb_, ts, es, ec, ev);

        lat = 0;
        while (!in_ready && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        check("idle_ready", 32'(in_ready), 32'd1);

        a = ta; b = tb_; sub = ts; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        if (!churn) in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); sub = 1'($urandom);

        lat = 0;
        seen = 0;
        while (!seen && lat < 40) begin
            if (out_valid) begin
                seen = 1;
            end else begin
                if (churn) begin
                    check("run_busy", 32'(in_ready), 32'd0);
                    a = W'($urandom); b = W'($urandom);
                end
                @(posedge clk); #1; lat++;
            end
        end
        in_valid = 1'b0;
        check("latency", 32'(lat), 32'(W));
        check("sum", 32'(sum), 32'(es));
        check("cout", 32'(cout), 32'(ec));
        check("overflow", 32'(overflow), 32'(ev));

        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_sum", 32'(sum), 32'(es));
            check("hold_cout", 32'(cout), 32'(ec));
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end

        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("release_valid", 32'(out_valid), 32'd0);
        check("release_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        sub       = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        #2 rst_n = 1'b1;

        do_op(8'h0F, 8'h01, 1'b0, 0, 1'b0);
        do_op(8'hFF, 8'h01, 1'b0, 0, 1'b0);
        do_op(8'h7F, 8'h01, 1'b0, 0, 1'b0);
        do_op(8'h05, 8'h03, 1'b1, 0, 1'b0);
        do_op(8'h03, 8'h05, 1'b1, 0, 1'b0);
        do_op(8'h80, 8'h01, 1'b1, 0, 1'b0);
        do_op(8'hA5, 8'h5A, 1'b0, 5, 1'b0);
        do_op(8'h3C, 8'hC7, 1'b1, 1, 1'b1);

        // Abort an all-carry add mid-run; the following op must not see a stale carry.
        @(posedge clk); #1;
        a = 8'hFF; b = 8'hFF; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check("arst_sum", 32'(sum), 32'd0);
        check("arst_cout", 32'(cout), 32'd0);
        check("arst_overflow", 32'(overflow), 32'd0);
        #1 rst_n = 1'b1;
        do_op(8'h12, 8'h34, 1'b0, 0, 1'b0);

        for (int k = 0; k < 20; k++)
            do_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
